// File: rtl/m2_pkg.sv
// Shared state, plane and geometry definitions for the block writer and the colour-conversion stage.
package m2_pkg;

  typedef enum logic [2:0] {IDLE, EVEN, ODD, BLK_ADV, FINISH} state_e;
  typedef enum logic [1:0] {PL_Y, PL_U, PL_V} plane_e;

  localparam logic [17:0] Y_BASE        = 18'd0;
  localparam logic [17:0] U_BASE        = 18'd38400;
  localparam logic [17:0] V_BASE        = 18'd57600;
  localparam logic [17:0] Y_WPR         = 18'd160;
  localparam logic [17:0] UV_WPR        = 18'd80;
  localparam logic [5:0]  Y_BCOLS       = 6'd40;
  localparam logic [5:0]  UV_BCOLS      = 6'd20;
  localparam logic [4:0]  BROWS         = 5'd30;
  localparam int unsigned BLOCK_SAMPLES = 64;

  function automatic logic [17:0] plane_base(input plane_e p);
    case (p)
      PL_U:    return U_BASE;
      PL_V:    return V_BASE;
      default: return Y_BASE;
    endcase
  endfunction

  function automatic logic [17:0] plane_wpr(input plane_e p);
    return (p == PL_Y) ? Y_WPR : UV_WPR;
  endfunction

  function automatic logic [5:0] plane_bcols(input plane_e p);
    return (p == PL_Y) ? Y_BCOLS : UV_BCOLS;
  endfunction

  function automatic plane_e next_plane(input plane_e p);
    case (p)
      PL_Y:    return PL_U;
      PL_U:    return PL_V;
      default: return PL_Y;
    endcase
  endfunction

endpackage

// File: rtl/m2_clip8.sv
// Combinational saturating clipper: signed 32-bit IDCT sample to unsigned 8-bit pixel.
module m2_clip8 (
  input  logic [31:0] i_sample,
  output logic [7:0]  o_pixel,
  output logic        o_clipped
);

  logic w_neg;
  logic w_big;

  assign w_neg = i_sample[31];
  assign w_big = !i_sample[31] && (|i_sample[30:8]);

  always_comb begin
    o_pixel = i_sample[7:0];
    if (w_neg) begin
      o_pixel = 8'd0;
    end else if (w_big) begin
      o_pixel = 8'd255;
    end
  end

  assign o_clipped = w_neg || w_big;

endmodule

// File: rtl/m2_block_writer.sv
// Writes clipped 8x8 IDCT blocks as packed pixel pairs into the raster Y/U/V SRAM regions.
// Optional M2_CLIP_COUNT_EN adds the saturating Clip_count output.
module m2_block_writer
  import m2_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [31:0] Sample_in,
  input  logic        Sample_valid,
  output logic        Sample_ready,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        Done
`ifdef M2_CLIP_COUNT_EN
  ,
  output logic [17:0] Clip_count
`endif
);

  state_e      r_state, w_state_d;
  plane_e      r_plane, w_plane_d;
  logic [5:0]  r_sample, w_sample_d;
  logic [5:0]  r_bcol, w_bcol_d;
  logic [4:0]  r_brow, w_brow_d;
  logic [7:0]  r_even;
  logic [17:0] r_addr;
  logic [15:0] r_data;
  logic        r_we_n;

  logic        w_accept;
  logic        w_last_block;
  logic [5:0]  w_bcols;
  logic [17:0] w_addr;
  logic [7:0]  w_pix;
  logic        w_clipped;

  m2_clip8 u_clip (
    .i_sample  (Sample_in),
    .o_pixel   (w_pix),
    .o_clipped (w_clipped)
  );

  assign Sample_ready = (r_state == EVEN) || (r_state == ODD);
  assign w_accept     = Sample_valid && Sample_ready;
  assign w_bcols      = plane_bcols(r_plane);
  assign w_last_block = (r_plane == PL_V) && (r_brow == BROWS - 5'd1) &&
                        (r_bcol == UV_BCOLS - 6'd1);

  // brow*8+r and bcol*4+c/2 are plain concatenations of the counters.
  assign w_addr = plane_base(r_plane) + 18'({r_brow, r_sample[5:3]}) * plane_wpr(r_plane) +
                  18'({r_bcol, r_sample[2:1]});

  always_comb begin
    w_state_d  = r_state;
    w_sample_d = r_sample;
    w_bcol_d   = r_bcol;
    w_brow_d   = r_brow;
    w_plane_d  = r_plane;
    case (r_state)
      IDLE: begin
        if (Start) begin
          w_state_d  = EVEN;
          w_sample_d = 6'd0;
          w_bcol_d   = 6'd0;
          w_brow_d   = 5'd0;
          w_plane_d  = PL_Y;
        end
      end
      EVEN: begin
        if (w_accept) begin
          w_state_d  = ODD;
          w_sample_d = r_sample + 6'd1;
        end
      end
      ODD: begin
        if (w_accept) begin
          w_sample_d = r_sample + 6'd1;
          w_state_d  = (r_sample == 6'(BLOCK_SAMPLES - 1)) ? BLK_ADV : EVEN;
        end
      end
      BLK_ADV: begin
        w_state_d = w_last_block ? FINISH : EVEN;
        if (r_bcol == w_bcols - 6'd1) begin
          w_bcol_d = 6'd0;
          if (r_brow == BROWS - 5'd1) begin
            w_brow_d  = 5'd0;
            w_plane_d = next_plane(r_plane);
          end else begin
            w_brow_d = r_brow + 5'd1;
          end
        end else begin
          w_bcol_d = r_bcol + 6'd1;
        end
      end
      FINISH:  w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_sample <= 6'd0;
      r_bcol   <= 6'd0;
      r_brow   <= 5'd0;
      r_plane  <= PL_Y;
      r_even   <= 8'd0;
      r_addr   <= 18'd0;
      r_data   <= 16'd0;
      r_we_n   <= 1'b1;
    end else begin
      r_state  <= w_state_d;
      r_sample <= w_sample_d;
      r_bcol   <= w_bcol_d;
      r_brow   <= w_brow_d;
      r_plane  <= w_plane_d;
      r_we_n   <= 1'b1;
      if (w_accept && (r_state == EVEN)) begin
        r_even <= w_pix;
      end
      if (w_accept && (r_state == ODD)) begin
        r_we_n <= 1'b0;
        r_addr <= w_addr;
        r_data <= {r_even, w_pix};
      end
    end
  end

`ifdef M2_CLIP_COUNT_EN
  logic [17:0] r_clip_cnt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_clip_cnt <= 18'd0;
    end else if ((r_state == IDLE) && Start) begin
      r_clip_cnt <= 18'd0;
    end else if (w_accept && w_clipped && (r_clip_cnt != '1)) begin
      r_clip_cnt <= r_clip_cnt + 18'd1;
    end
  end

  assign Clip_count = r_clip_cnt;
`else
  logic w_unused;
  assign w_unused = w_clipped;
`endif

  assign SRAM_address    = r_addr;
  assign SRAM_write_data = r_data;
  assign SRAM_we_n       = r_we_n;
  assign Done            = (r_state == FINISH);

endmodule

// File: tb/tb_m2_block_writer.sv
// Directed self-checking bench for m2_block_writer; far plane positions are reached by
// forcing the block counters so the run stays short.
module tb_m2_block_writer;
  import m2_pkg::*;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [31:0] Sample_in;
  logic        Sample_valid;
  logic        Sample_ready;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        Done;
`ifdef M2_CLIP_COUNT_EN
  logic [17:0] Clip_count;
`endif

  int errors = 0;
  int checks = 0;

  logic [17:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int          done_cnt = 0;

  plane_e      j_plane;
  logic [4:0]  j_brow;
  logic [5:0]  j_bcol;

  m2_block_writer dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .Start           (Start),
    .Sample_in       (Sample_in),
    .Sample_valid    (Sample_valid),
    .Sample_ready    (Sample_ready),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n),
    .Done            (Done)
`ifdef M2_CLIP_COUNT_EN
    ,
    .Clip_count      (Clip_count)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Capture every SRAM write and Done pulse, sampled away from the active edge.
  always @(negedge Clock) begin
    if (SRAM_we_n === 1'b0) begin
      wr_addr_q.push_back(SRAM_address);
      wr_data_q.push_back(SRAM_write_data);
    end
    if (Done === 1'b1) done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic clr_q();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    Start = 1'b0;
    Sample_valid = 1'b0;
    Sample_in = 32'd0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    clr_q();
  endtask

  task automatic pulse_start();
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  // Present one sample and return right after the edge that accepts it.
  task automatic send(input logic [31:0] v);
    int n = 0;
    @(negedge Clock);
    Sample_in = v;
    Sample_valid = 1'b1;
    while (Sample_ready !== 1'b1 && n < 200) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 200) begin
      errors++;
      $display("FAIL send_timeout: ready=%b after %0d cycles, required 1", Sample_ready, n);
    end
    @(posedge Clock);
  endtask

  task automatic settle();
    @(negedge Clock);
    Sample_valid = 1'b0;
    @(negedge Clock);
  endtask

  task automatic jump(input plane_e p, input logic [4:0] br, input logic [5:0] bc);
    j_plane = p;
    j_brow  = br;
    j_bcol  = bc;
    @(negedge Clock);
    Sample_valid = 1'b0;
    force dut.r_plane = j_plane;
    force dut.r_brow  = j_brow;
    force dut.r_bcol  = j_bcol;
    @(negedge Clock);
    release dut.r_plane;
    release dut.r_brow;
    release dut.r_bcol;
  endtask

  task automatic run_from(input plane_e p, input logic [4:0] br, input logic [5:0] bc,
                          input int n);
    do_reset();
    pulse_start();
    jump(p, br, bc);
    clr_q();
    for (int k = 0; k < n; k++) send(32'(k));
    settle();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (Sample_ready !== 1'b0) begin errors++;
      $display("FAIL rst_ready: got %b want 0", Sample_ready); end
    checks++; if (SRAM_we_n !== 1'b1) begin errors++;
      $display("FAIL rst_we_n: got %b want 1", SRAM_we_n); end
    checks++; if (SRAM_address !== 18'd0) begin errors++;
      $display("FAIL rst_addr: got %0d want 0", SRAM_address); end
    checks++; if (SRAM_write_data !== 16'd0) begin errors++;
      $display("FAIL rst_data: got %h want 0000", SRAM_write_data); end
    checks++; if (Done !== 1'b0) begin errors++;
      $display("FAIL rst_done: got %b want 0", Done); end
`ifdef M2_CLIP_COUNT_EN
    checks++; if (Clip_count !== 18'd0) begin errors++;
      $display("FAIL rst_clip_count: got %0d want 0", Clip_count); end
`endif
  endtask

  task automatic test_block0();
    logic [17:0] ea;
    logic [15:0] ed;
    pulse_start();
    clr_q();
    for (int k = 0; k < 64; k++) send(32'(k));
    @(negedge Clock);
    Sample_valid = 1'b0;
    checks++; if (Sample_ready !== 1'b0) begin errors++;
      $display("FAIL blk_bubble: ready got %b want 0", Sample_ready); end
    @(negedge Clock);
    checks++; if (Sample_ready !== 1'b1) begin errors++;
      $display("FAIL blk_after_bubble: ready got %b want 1", Sample_ready); end
    checks++; if (wr_addr_q.size() != 32) begin errors++;
      $display("FAIL blk_write_count: got %0d want 32", wr_addr_q.size()); end
    for (int i = 0; i < 32 && i < wr_addr_q.size(); i++) begin
      ea = 18'((i / 4) * 160 + (i % 4));
      ed = {8'(2 * i), 8'(2 * i + 1)};
      checks++; if (wr_addr_q[i] !== ea) begin errors++;
        $display("FAIL blk_addr[%0d]: got %0d want %0d", i, wr_addr_q[i], ea); end
      checks++; if (wr_data_q[i] !== ed) begin errors++;
        $display("FAIL blk_data[%0d]: got %h want %h", i, wr_data_q[i], ed); end
    end
  endtask

  // Continues in block 1 (bcol 1); the Start pulse here must be ignored.
  task automatic test_clip();
    logic [17:0] ea[3];
    logic [15:0] ed[3];
    ea = '{18'd4, 18'd5, 18'd6};
    ed = '{16'h00FF, 16'h00FF, 16'hFF00};
    pulse_start();
    clr_q();
    send(32'hFFFF_FFFB);
    send(32'd300);
    send(32'd0);
    send(32'd255);
    send(32'd256);
    send(32'hFFFF_FFFF);
    settle();
    checks++; if (wr_addr_q.size() != 3) begin errors++;
      $display("FAIL clip_write_count: got %0d want 3", wr_addr_q.size()); end
    for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
      checks++; if (wr_addr_q[i] !== ea[i]) begin errors++;
        $display("FAIL clip_addr[%0d]: got %0d want %0d", i, wr_addr_q[i], ea[i]); end
      checks++; if (wr_data_q[i] !== ed[i]) begin errors++;
        $display("FAIL clip_data[%0d]: got %h want %h", i, wr_data_q[i], ed[i]); end
    end
`ifdef M2_CLIP_COUNT_EN
    checks++; if (Clip_count !== 18'd4) begin errors++;
      $display("FAIL clip_count: got %0d want 4", Clip_count); end
`endif
  endtask

  task automatic test_plane_edges();
    run_from(PL_U, 5'd0, 6'd0, 2);
    checks++; if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 18'd38400) begin errors++;
      $display("FAIL edge_u_first: got %0d want 38400", wr_addr_q[0]); end
    run_from(PL_U, 5'd0, 6'd1, 2);
    checks++; if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 18'd38404) begin errors++;
      $display("FAIL edge_u_bcol1: got %0d want 38404", wr_addr_q[0]); end
    run_from(PL_U, 5'd1, 6'd0, 2);
    checks++; if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 18'd39040) begin errors++;
      $display("FAIL edge_u_brow1: got %0d want 39040", wr_addr_q[0]); end
    run_from(PL_Y, 5'd29, 6'd39, 66);
    checks++; if (wr_addr_q.size() != 33) begin errors++;
      $display("FAIL edge_y_count: got %0d want 33", wr_addr_q.size()); end
    else begin
      checks++; if (wr_addr_q[31] !== 18'd38399) begin errors++;
        $display("FAIL edge_y_last: got %0d want 38399", wr_addr_q[31]); end
      checks++; if (wr_data_q[31] !== 16'h3E3F) begin errors++;
        $display("FAIL edge_y_last_data: got %h want 3e3f", wr_data_q[31]); end
      checks++; if (wr_addr_q[32] !== 18'd38400) begin errors++;
        $display("FAIL edge_y_to_u: got %0d want 38400", wr_addr_q[32]); end
      checks++; if (wr_data_q[32] !== 16'h4041) begin errors++;
        $display("FAIL edge_y_to_u_data: got %h want 4041", wr_data_q[32]); end
    end
    run_from(PL_U, 5'd0, 6'd19, 66);
    checks++; if (wr_addr_q.size() != 33) begin errors++;
      $display("FAIL edge_bcol_wrap_count: got %0d want 33", wr_addr_q.size()); end
    else begin
      checks++; if (wr_addr_q[31] !== 18'd39039) begin errors++;
        $display("FAIL edge_bcol_last: got %0d want 39039", wr_addr_q[31]); end
      checks++; if (wr_addr_q[32] !== 18'd39040) begin errors++;
        $display("FAIL edge_bcol_wrap: got %0d want 39040", wr_addr_q[32]); end
    end
    run_from(PL_U, 5'd29, 6'd19, 66);
    checks++; if (wr_addr_q.size() != 33) begin errors++;
      $display("FAIL edge_u_to_v_count: got %0d want 33", wr_addr_q.size()); end
    else begin
      checks++; if (wr_addr_q[31] !== 18'd57599) begin errors++;
        $display("FAIL edge_u_last: got %0d want 57599", wr_addr_q[31]); end
      checks++; if (wr_addr_q[32] !== 18'd57600) begin errors++;
        $display("FAIL edge_v_first: got %0d want 57600", wr_addr_q[32]); end
    end
  endtask

  task automatic test_gaps();
    logic just_odd;
    logic exp_we;
    int   ng;
    do_reset();
    pulse_start();
    clr_q();
    just_odd = 1'b0;
    for (int k = 0; k < 64; k++) begin
      ng = int'($urandom_range(0, 2));
      for (int g = 0; g < ng; g++) begin
        @(negedge Clock);
        Sample_valid = 1'b0;
        exp_we = ~just_odd;
        checks++; if (SRAM_we_n !== exp_we) begin errors++;
          $display("FAIL gap_we_n k=%0d: got %b want %b", k, SRAM_we_n, exp_we); end
        just_odd = 1'b0;
      end
      @(negedge Clock);
      Sample_valid = 1'b1;
      Sample_in = 32'(k);
      exp_we = ~just_odd;
      checks++; if (SRAM_we_n !== exp_we) begin errors++;
        $display("FAIL gap_we_n_valid k=%0d: got %b want %b", k, SRAM_we_n, exp_we); end
      checks++; if (Sample_ready !== 1'b1) begin errors++;
        $display("FAIL gap_ready k=%0d: got %b want 1", k, Sample_ready); end
      @(posedge Clock);
      just_odd = (k % 2) == 1;
    end
    settle();
    checks++; if (wr_addr_q.size() != 32) begin errors++;
      $display("FAIL gap_write_count: got %0d want 32", wr_addr_q.size()); end
    for (int i = 0; i < 32 && i < wr_addr_q.size(); i++) begin
      checks++; if (wr_addr_q[i] !== 18'((i / 4) * 160 + (i % 4)) ||
                    wr_data_q[i] !== {8'(2 * i), 8'(2 * i + 1)}) begin errors++;
        $display("FAIL gap_write[%0d]: got %0d/%h want %0d/%h", i, wr_addr_q[i], wr_data_q[i],
                 (i / 4) * 160 + (i % 4), {8'(2 * i), 8'(2 * i + 1)}); end
    end
  endtask

  task automatic test_full_image();
    do_reset();
    pulse_start();
    jump(PL_V, 5'd29, 6'd19);
    clr_q();
    done_cnt = 0;
    for (int k = 0; k < 64; k++) send(32'(k));
    Sample_in = 32'd99;
    @(negedge Clock);
    checks++; if (SRAM_we_n !== 1'b0 || SRAM_address !== 18'd76799) begin errors++;
      $display("FAIL img_last_write: we_n=%b addr=%0d want 0/76799", SRAM_we_n, SRAM_address); end
    checks++; if (Done !== 1'b0 || Sample_ready !== 1'b0) begin errors++;
      $display("FAIL img_cycle1: done=%b ready=%b want 0/0", Done, Sample_ready); end
    @(negedge Clock);
    checks++; if (Done !== 1'b1 || Sample_ready !== 1'b0) begin errors++;
      $display("FAIL img_done: done=%b ready=%b want 1/0", Done, Sample_ready); end
    @(negedge Clock);
    checks++; if (Done !== 1'b0 || Sample_ready !== 1'b0) begin errors++;
      $display("FAIL img_idle: done=%b ready=%b want 0/0", Done, Sample_ready); end
    repeat (3) @(negedge Clock);
    Sample_valid = 1'b0;
    @(negedge Clock);
    checks++; if (done_cnt != 1) begin errors++;
      $display("FAIL img_done_count: got %0d want 1", done_cnt); end
    checks++; if (wr_addr_q.size() != 32) begin errors++;
      $display("FAIL img_write_count: got %0d want 32", wr_addr_q.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse_start();
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 64; k++) send(32'(k));
    end
    for (int k = 0; k < 10; k++) send(32'd300);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    checks++; if (SRAM_we_n !== 1'b1 || Sample_ready !== 1'b0) begin errors++;
      $display("FAIL mid_rst: we_n=%b ready=%b want 1/0", SRAM_we_n, Sample_ready); end
    checks++; if (SRAM_address !== 18'd0 || Done !== 1'b0) begin errors++;
      $display("FAIL mid_rst_addr: addr=%0d done=%b want 0/0", SRAM_address, Done); end
`ifdef M2_CLIP_COUNT_EN
    checks++; if (Clip_count !== 18'd0) begin errors++;
      $display("FAIL mid_rst_clip: got %0d want 0", Clip_count); end
`endif
    Reset = 1'b0;
    Sample_valid = 1'b0;
    pulse_start();
    clr_q();
    send(32'd7);
    send(32'd9);
    settle();
    checks++; if (wr_addr_q.size() != 1) begin errors++;
      $display("FAIL mid_restart_count: got %0d want 1", wr_addr_q.size()); end
    else begin
      checks++; if (wr_addr_q[0] !== 18'd0 || wr_data_q[0] !== 16'h0709) begin errors++;
        $display("FAIL mid_restart: got %0d/%h want 0/0709", wr_addr_q[0], wr_data_q[0]); end
    end
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Sample_valid = 1'b0;
    Sample_in = 32'd0;
    test_reset();
    test_block0();
    test_clip();
    test_plane_edges();
    test_gaps();
    test_full_image();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
